// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader: FSM states, error codes and the default frame marker.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR_ADDR = 3'd1,
    ST_HDR_LEN  = 3'd2,
    ST_DATA     = 3'd3,
    ST_CSUM     = 3'd4,
    ST_VERIFY   = 3'd5,
    ST_RUN      = 3'd6,
    ST_ERR      = 3'd7
  } loader_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_CSUM     = 2'd1,
    ERR_READBACK = 2'd2
  } loader_err_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // A length byte of zero encodes a full 256-byte payload.
  function automatic logic [8:0] len_decode(input logic [7:0] len_byte);
    if (len_byte == 8'd0) begin
      len_decode = 9'd256;
    end else begin
      len_decode = {1'b0, len_byte};
    end
  endfunction

endpackage

// File: rtl/loader_csum.sv
// Mod-256 byte accumulator used for the frame checksum and the payload/readback sums.
module loader_csum
  import prog_loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] din,
  output logic [7:0] value
);

  logic [7:0] acc_r;

  // Running sum; clr restarts it and a same-cycle add becomes the first term.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r <= 8'd0;
    end else begin
      acc_r <= (clr ? 8'd0 : acc_r) + (add ? din : 8'd0);
    end
  end

  assign value = acc_r;

endmodule

// File: rtl/prog_loader.sv
// Framed-stream program loader: writes payload bytes to RAM and holds the CPU until the frame checks out.
// Define PROG_LOADER_READBACK_EN to re-read and re-sum the image from RAM before releasing the CPU.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  loader_state_e     state_r;
  loader_state_e     state_nx_s;
  logic              acc_s;
  logic              start_s;
  logic              csum_acc_s;
  logic              csum_ok_s;
  logic              fsum_add_s;
  logic              dsum_clr_s;
  logic              dsum_add_s;
  logic [7:0]        fsum_s;
  logic [7:0]        dsum_s;
  logic [7:0]        dsum_din_s;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [8:0]        rem_r;
  logic [7:0]        mem_wdata_r;
  logic              mem_we_r;
  logic              in_ready_r;
  logic              cpu_hold_r;
  logic              done_r;
  logic              error_r;
  loader_err_e       err_code_r;
  logic              in_ready_nx_s;
  logic              cpu_hold_nx_s;
  logic              done_nx_s;
  logic              error_nx_s;
  loader_err_e       err_code_nx_s;
`ifdef PROG_LOADER_READBACK_EN
  logic [ADDR_W-1:0] base_r;
  logic [8:0]        len_r;
  logic [8:0]        rd_left_r;
  logic [8:0]        rcv_left_r;
  logic              rd_pend_r;
  logic              rdv_r;
  logic [7:0]        data_sum_r;
  logic              rb_last_s;
  logic              rb_ok_s;
`else
  logic              unused_s;
`endif

  assign acc_s      = in_valid & in_ready_r;
  assign start_s    = acc_s && (in_data == SYNC_BYTE) &&
                      (state_r inside {ST_IDLE, ST_RUN, ST_ERR});
  assign csum_acc_s = acc_s && (state_r == ST_CSUM);
  assign csum_ok_s  = ((fsum_s + in_data) == 8'd0);
  assign fsum_add_s = acc_s && (state_r inside {ST_HDR_ADDR, ST_HDR_LEN, ST_DATA});

`ifdef PROG_LOADER_READBACK_EN
  assign rb_last_s = (state_r == ST_VERIFY) && rdv_r && (rcv_left_r == 9'd1);
  assign rb_ok_s   = ((dsum_s + mem_rdata) == data_sum_r);
`else
  assign unused_s  = ^{mem_rdata, dsum_s};
`endif

  // Payload-sum controls: accumulates data bytes, then (with readback) the re-read bytes.
  always_comb begin
    dsum_clr_s = start_s;
    dsum_add_s = acc_s && (state_r == ST_DATA);
    dsum_din_s = in_data;
`ifdef PROG_LOADER_READBACK_EN
    if (state_r == ST_VERIFY) begin
      dsum_clr_s = 1'b0;
      dsum_add_s = rdv_r;
      dsum_din_s = mem_rdata;
    end else if (csum_acc_s) begin
      dsum_clr_s = 1'b1;
      dsum_add_s = 1'b0;
      dsum_din_s = in_data;
    end else begin
      dsum_din_s = in_data;
    end
`endif
  end

  loader_csum u_frame_sum (
    .clk   (clk),
    .reset (reset),
    .clr   (start_s),
    .add   (fsum_add_s),
    .din   (in_data),
    .value (fsum_s)
  );

  loader_csum u_data_sum (
    .clk   (clk),
    .reset (reset),
    .clr   (dsum_clr_s),
    .add   (dsum_add_s),
    .din   (dsum_din_s),
    .value (dsum_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start_s) begin
          state_nx_s = ST_HDR_ADDR;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_HDR_ADDR: begin
        if (acc_s) begin
          state_nx_s = ST_HDR_LEN;
        end else begin
          state_nx_s = ST_HDR_ADDR;
        end
      end
      ST_HDR_LEN: begin
        if (acc_s) begin
          state_nx_s = ST_DATA;
        end else begin
          state_nx_s = ST_HDR_LEN;
        end
      end
      ST_DATA: begin
        if (acc_s && (rem_r == 9'd1)) begin
          state_nx_s = ST_CSUM;
        end else begin
          state_nx_s = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (!acc_s) begin
          state_nx_s = ST_CSUM;
        end else if (csum_ok_s) begin
`ifdef PROG_LOADER_READBACK_EN
          state_nx_s = ST_VERIFY;
`else
          state_nx_s = ST_RUN;
`endif
        end else begin
          state_nx_s = ST_ERR;
        end
      end
`ifdef PROG_LOADER_READBACK_EN
      ST_VERIFY: begin
        if (!rb_last_s) begin
          state_nx_s = ST_VERIFY;
        end else if (rb_ok_s) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_ERR;
        end
      end
`endif
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the status outputs, decided on state transitions.
  always_comb begin
    cpu_hold_nx_s = cpu_hold_r;
    done_nx_s     = done_r;
    error_nx_s    = error_r;
    err_code_nx_s = err_code_r;
    in_ready_nx_s = (state_nx_s != ST_VERIFY);
    if (start_s) begin
      cpu_hold_nx_s = 1'b1;
      done_nx_s     = 1'b0;
      error_nx_s    = 1'b0;
      err_code_nx_s = ERR_NONE;
    end else if ((state_nx_s == ST_RUN) && (state_r != ST_RUN)) begin
      cpu_hold_nx_s = 1'b0;
      done_nx_s     = 1'b1;
      error_nx_s    = 1'b0;
      err_code_nx_s = ERR_NONE;
    end else if ((state_nx_s == ST_ERR) && (state_r != ST_ERR)) begin
      cpu_hold_nx_s = 1'b1;
      done_nx_s     = 1'b0;
      error_nx_s    = 1'b1;
      err_code_nx_s = (state_r == ST_VERIFY) ? ERR_READBACK : ERR_CSUM;
    end else begin
      cpu_hold_nx_s = cpu_hold_r;
    end
  end

  // Status output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_r <= 1'b0;
      cpu_hold_r <= 1'b1;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      err_code_r <= ERR_NONE;
    end else begin
      in_ready_r <= in_ready_nx_s;
      cpu_hold_r <= cpu_hold_nx_s;
      done_r     <= done_nx_s;
      error_r    <= error_nx_s;
      err_code_r <= err_code_nx_s;
    end
  end

  // RAM port and frame bookkeeping: header capture, write pipeline and readback sequencing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r       <= '0;
      rem_r       <= 9'd0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 8'd0;
      mem_we_r    <= 1'b0;
`ifdef PROG_LOADER_READBACK_EN
      base_r      <= '0;
      len_r       <= 9'd0;
      rd_left_r   <= 9'd0;
      rcv_left_r  <= 9'd0;
      rd_pend_r   <= 1'b0;
      rdv_r       <= 1'b0;
      data_sum_r  <= 8'd0;
`endif
    end else begin
      mem_we_r <= 1'b0;
      case (state_r)
        ST_HDR_ADDR: begin
          if (acc_s) begin
            ptr_r  <= ADDR_W'(in_data);
`ifdef PROG_LOADER_READBACK_EN
            base_r <= ADDR_W'(in_data);
`endif
          end
        end
        ST_HDR_LEN: begin
          if (acc_s) begin
            rem_r <= len_decode(in_data);
`ifdef PROG_LOADER_READBACK_EN
            len_r <= len_decode(in_data);
`endif
          end
        end
        ST_DATA: begin
          if (acc_s) begin
            mem_we_r    <= 1'b1;
            mem_addr_r  <= ptr_r;
            mem_wdata_r <= in_data;
            ptr_r       <= ptr_r + ADDR_W'(1);
            rem_r       <= rem_r - 9'd1;
          end
        end
`ifdef PROG_LOADER_READBACK_EN
        ST_CSUM: begin
          // First read address goes out in the first VERIFY cycle.
          if (acc_s) begin
            mem_addr_r <= base_r;
            ptr_r      <= base_r + ADDR_W'(1);
            rd_left_r  <= len_r - 9'd1;
            rcv_left_r <= len_r;
            rd_pend_r  <= 1'b1;
            rdv_r      <= 1'b0;
            data_sum_r <= dsum_s;
          end
        end
        ST_VERIFY: begin
          rdv_r <= rd_pend_r;
          if (rd_left_r != 9'd0) begin
            mem_addr_r <= ptr_r;
            ptr_r      <= ptr_r + ADDR_W'(1);
            rd_left_r  <= rd_left_r - 9'd1;
            rd_pend_r  <= 1'b1;
          end else begin
            rd_pend_r  <= 1'b0;
          end
          if (rdv_r) begin
            rcv_left_r <= rcv_left_r - 9'd1;
          end
        end
`endif
        default: begin
          mem_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_we    = mem_we_r;
  assign cpu_hold  = cpu_hold_r;
  assign done      = done_r;
  assign error     = error_r;
  assign err_code  = err_code_r;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected RAM writes and status changes are queued with their cycle.
module tb_prog_loader;

`ifdef PROG_LOADER_READBACK_EN
  localparam int RB_LAT = 4;
`else
  localparam int RB_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       cpu_hold;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  typedef struct { logic [7:0] addr; logic [7:0] data; int cyc; } wr_t;
  typedef struct { logic [4:0] st; int cyc; } st_t;

  wr_t        wr_q[$];
  st_t        st_q[$];
  int         cyc = 0;
  int         check_cnt = 0;
  int         pass_cnt = 0;
  bit         term = 1'b0;
  bit         corrupt11 = 1'b0;
  bit         wipe = 1'b0;
  logic [4:0] prev_st = 5'b10000;
  logic [7:0] ram [0:255];

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM model, 1-cycle read latency; optional corruption of address 0x11.
  always @(posedge clk) begin
    if (wipe) begin
      ram[8'h10] <= 8'h00;
      ram[8'h11] <= 8'h00;
      ram[8'h12] <= 8'h00;
    end else if (mem_we) begin
      ram[mem_addr] <= (corrupt11 && mem_addr == 8'h11) ? 8'h23 : mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Monitor: pops the write queue on every mem_we and the status queue on every status change.
  always @(negedge clk) begin : mon
    wr_t        w;
    st_t        s;
    logic [4:0] cur;
    cur = {cpu_hold, done, error, err_code};
    if (reset === 1'b1) begin
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          check_cnt++;
          $display("FAIL wr_unexpected: got write addr %h data %h at cycle %0d, required none", mem_addr, mem_wdata, cyc);
        end else begin
          w = wr_q.pop_front();
          check("write", {cyc[15:0], mem_addr, mem_wdata}, {w.cyc[15:0], w.addr, w.data});
        end
      end
      if (cur !== prev_st) begin
        if (st_q.size() == 0) begin
          check_cnt++;
          $display("FAIL st_unexpected: got status %b at cycle %0d, required no change", cur, cyc);
        end else begin
          s = st_q.pop_front();
          check("status", {cyc[15:0], 11'd0, cur}, {s.cyc[15:0], 11'd0, s.st});
        end
      end
    end
    prev_st = cur;
  end

  task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = b;
    acc = -1;
    n = 0;
    while (acc < 0 && n < 50) begin
      @(negedge clk);
      if (in_ready) acc = cyc;
      else n++;
    end
    if (acc < 0) begin
      check_cnt++;
      $display("FAIL send_timeout: byte %h not accepted within 50 cycles, required acceptance", b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Three-byte frame; status {hold,done,error,code} and write cycles are queued as bytes are accepted.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] cs, input bit gaps,
                            input bit ok, input logic [1:0] code);
    logic [7:0] fb [0:6];
    int k;
    int g;
    fb = '{8'hA5, a, 8'h03, d0, d1, d2, cs};
    for (int i = 0; i < 7; i++) begin
      g = gaps ? int'($urandom_range(0, 3)) : 0;
      send_byte(fb[i], g, k);
      if (i == 0 && term) st_q.push_back('{5'b10000, k + 1});
      if (i >= 3 && i <= 5) wr_q.push_back('{a + 8'(i - 3), fb[i], k + 1});
    end
    if (ok) st_q.push_back('{5'b01000, k + 1 + RB_LAT});
    else if (code == 2'd1) st_q.push_back('{{3'b101, code}, k + 1});
    else st_q.push_back('{{3'b101, code}, k + 1 + RB_LAT});
    term = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_status", {26'd0, cpu_hold, done, error, err_code, mem_we}, {26'd0, 6'b100000});
    check("rst_mem_bus", {16'd0, mem_addr, mem_wdata}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("in_ready_rises", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // 1: basic load; 0x10+0x03+0x11+0x22+0x33+0x87 = 0x100
    send_frame(8'h10, 8'h11, 8'h22, 8'h33, 8'h87, 1'b0, 1'b1, 2'd0);
    repeat (8) @(posedge clk);
    #1 wipe = 1'b1;
    @(posedge clk);
    #1 wipe = 1'b0;

    // 2: bad checksum, writes remain in RAM
    send_frame(8'h10, 8'h11, 8'h22, 8'h33, 8'h88, 1'b0, 1'b0, 2'd1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("t2_ram10", {24'd0, ram[8'h10]}, 32'h11);
    check("t2_ram11", {24'd0, ram[8'h11]}, 32'h22);
    check("t2_ram12", {24'd0, ram[8'h12]}, 32'h33);
    @(posedge clk);
    #1;

    // 3: address wrap FE,FF,00; 0xFE+0x03+0x01+0x02+0x03+0xF9 = 0x200
    send_frame(8'hFE, 8'h01, 8'h02, 8'h03, 8'hF9, 1'b0, 1'b1, 2'd0);
    repeat (8) @(posedge clk);
    #1;

    // 4: garbage dropped, then frame 1 with valid gaps
    send_byte(8'h00, 0, k);
    send_byte(8'hFF, 1, k);
    send_byte(8'h5A, 2, k);
    send_frame(8'h10, 8'h11, 8'h22, 8'h33, 8'h87, 1'b1, 1'b1, 2'd0);
    repeat (8) @(posedge clk);
    #1;

    // 5: reset after the second data byte
    send_byte(8'hA5, 0, k);
    st_q.push_back('{5'b10000, k + 1});
    send_byte(8'h10, 0, k);
    send_byte(8'h03, 0, k);
    send_byte(8'h11, 0, k);
    wr_q.push_back('{8'h10, 8'h11, k + 1});
    send_byte(8'h22, 0, k);
    wr_q.push_back('{8'h11, 8'h22, k + 1});
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_status", {26'd0, cpu_hold, done, error, err_code, mem_we}, {26'd0, 6'b100000});
    check("midrst_mem_bus", {16'd0, mem_addr, mem_wdata}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    term = 1'b0;
    @(posedge clk);
    #1;
    send_byte(8'h33, 0, k);
    send_byte(8'h87, 0, k);
    send_frame(8'h10, 8'h11, 8'h22, 8'h33, 8'h87, 1'b0, 1'b1, 2'd0);
    repeat (8) @(posedge clk);
    #1;

`ifdef PROG_LOADER_READBACK_EN
    // 6: readback catches corrupted RAM, then a clean frame releases after the verify pass
    corrupt11 = 1'b1;
    send_frame(8'h10, 8'h11, 8'h22, 8'h33, 8'h87, 1'b0, 1'b0, 2'd2);
    @(negedge clk);
    check("verify_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (8) @(posedge clk);
    #1 corrupt11 = 1'b0;
    send_frame(8'h10, 8'h11, 8'h22, 8'h33, 8'h87, 1'b0, 1'b1, 2'd0);
    repeat (8) @(posedge clk);
    #1;
`endif

    repeat (10) @(posedge clk);
    @(negedge clk);
    check("wr_q_drained", wr_q.size(), 32'd0);
    check("st_q_drained", st_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
